// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT panel timing generator with power sequencing and pixel request/return path
// Requests pixels from counters; returned data is aligned to DE/sync through a PIX_LAT-deep delay line.
module tft_timing_gen #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIX_LAT  = 2,
   parameter int PWR_DLY  = 1024,
   parameter int X_BITS   = 10,
   parameter int Y_BITS   = 9,
   parameter int C_BITS   = 8
) (
   input  logic              tft_clk,
   input  logic              rst,
   input  logic              enable,
   output logic              req_valid,
   output logic [X_BITS-1:0] req_x,
   output logic [Y_BITS-1:0] req_y,
   input  logic [C_BITS-1:0] pix_red,
   input  logic [C_BITS-1:0] pix_green,
   input  logic [C_BITS-1:0] pix_blue,
   output logic [C_BITS-1:0] tft_red,
   output logic [C_BITS-1:0] tft_green,
   output logic [C_BITS-1:0] tft_blue,
   output logic              tft_data_ena,
   output logic              tft_hsync,
   output logic              tft_vsync,
   output logic              tft_vdd,
   output logic              tft_display,
   output logic              new_frame,
   output logic              running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [X_BITS-1:0] H_ACT_C  = X_BITS'(H_ACTIVE);
   localparam logic [X_BITS-1:0] H_SS_C   = X_BITS'(H_ACTIVE + H_FP);
   localparam logic [X_BITS-1:0] H_SE_C   = X_BITS'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [X_BITS-1:0] H_LAST_C = X_BITS'(H_TOTAL - 1);
   localparam logic [Y_BITS-1:0] V_ACT_C  = Y_BITS'(V_ACTIVE);
   localparam logic [Y_BITS-1:0] V_SS_C   = Y_BITS'(V_ACTIVE + V_FP);
   localparam logic [Y_BITS-1:0] V_SE_C   = Y_BITS'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [Y_BITS-1:0] V_LAST_C = Y_BITS'(V_TOTAL - 1);
   localparam int DW = $clog2(PWR_DLY + 1);
   localparam logic [DW-1:0] DLY_LOAD = DW'(PWR_DLY);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_VDD_WAIT,
      ST_RUN,
      ST_DRAIN,
      ST_DISP_OFF
   } state_t;

   state_t                    state_q, state_d;
   logic [DW-1:0]             dly_q, dly_d;
   logic [X_BITS-1:0]         h_q, h_d;
   logic [Y_BITS-1:0]         v_q, v_d;
   logic [PIX_LAT-1:0][2:0]   pipe_q, pipe_d;
   logic [2:0]                tap;
   logic                      run, at_last, flush;
   logic                      raw_hs, raw_vs;
   logic                      de_q, hs_q, vs_q, vdd_q, disp_q;
   logic [C_BITS-1:0]         red_q, green_q, blue_q;

   assign run     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign at_last = (h_q == H_LAST_C) && (v_q == V_LAST_C);
   assign flush   = (state_q == ST_DISP_OFF);

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      case (state_q)
         ST_OFF: begin
            if (enable) begin
               state_d = ST_VDD_WAIT;
               dly_d   = DLY_LOAD;
            end
         end
         ST_VDD_WAIT: begin
            if (!enable) begin
               state_d = ST_OFF;
               dly_d   = '0;
            end else if (dly_q == DW'(1)) begin
               state_d = ST_RUN;
               dly_d   = '0;
            end else begin
               dly_d = dly_q - DW'(1);
            end
         end
         ST_RUN: begin
            if (!enable) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (at_last) begin
               state_d = ST_DISP_OFF;
               dly_d   = DLY_LOAD;
            end
         end
         ST_DISP_OFF: begin
            if (dly_q == DW'(1)) begin
               state_d = ST_OFF;
               dly_d   = '0;
            end else begin
               dly_d = dly_q - DW'(1);
            end
         end
         default: begin
            state_d = ST_OFF;
            dly_d   = '0;
         end
      endcase
   end

   // Counters sit at (0,0) whenever the panel is not scanning.
   always_comb begin
      h_d = '0;
      v_d = '0;
      if (run) begin
         if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + Y_BITS'(1);
         end else begin
            h_d = h_q + X_BITS'(1);
            v_d = v_q;
         end
      end
   end

   assign req_valid = run && (h_q < H_ACT_C) && (v_q < V_ACT_C);
   assign req_x     = h_q;
   assign req_y     = v_q;
   assign new_frame = run && (h_q == '0) && (v_q == '0);
   assign running   = run;
   assign raw_hs    = run && (h_q >= H_SS_C) && (h_q < H_SE_C);
   assign raw_vs    = run && (v_q >= V_SS_C) && (v_q < V_SE_C);

   // Delay line entries are {vsync, hsync, de}, all active-high internally.
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = {raw_vs, raw_hs, req_valid};
      for (int i = 1; i < PIX_LAT; i++) pipe_d[i] = pipe_q[i-1];
      if (flush) pipe_d = '0;
      tap = flush ? 3'b000 : pipe_q[PIX_LAT-1];
   end

   always_ff @(posedge tft_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         dly_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         pipe_q  <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         vdd_q   <= 1'b0;
         disp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pipe_q  <= pipe_d;
         de_q    <= tap[0];
         hs_q    <= ~(tap[1] ^ SYNC_POL);
         vs_q    <= ~(tap[2] ^ SYNC_POL);
         red_q   <= tap[0] ? pix_red   : '0;
         green_q <= tap[0] ? pix_green : '0;
         blue_q  <= tap[0] ? pix_blue  : '0;
         vdd_q   <= (state_d != ST_OFF);
         disp_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      end
   end

   assign tft_data_ena = de_q;
   assign tft_hsync    = hs_q;
   assign tft_vsync    = vs_q;
   assign tft_red      = red_q;
   assign tft_green    = green_q;
   assign tft_blue     = blue_q;
   assign tft_vdd      = vdd_q;
   assign tft_display  = disp_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - directed bench for tft_timing_gen (H 4/1/1/1, V 3/1/1/1, PIX_LAT 2, PWR_DLY 3)
module tb_tft_timing_gen;

   logic       tft_clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       req_valid;
   logic [3:0] req_x, req_y;
   logic [7:0] pix_red, pix_green, pix_blue;
   logic [7:0] tft_red, tft_green, tft_blue;
   logic       tft_data_ena, tft_hsync, tft_vsync, tft_vdd, tft_display;
   logic       new_frame, running;
   logic [7:0] p0 = 8'h00, p1 = 8'h00;

   int checks = 0;
   int failures = 0;
   int c = 0;

   tft_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .PIX_LAT(2), .PWR_DLY(3),
      .X_BITS(4), .Y_BITS(4), .C_BITS(8)
   ) dut (
      .tft_clk(tft_clk), .rst(rst), .enable(enable),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
      .tft_red(tft_red), .tft_green(tft_green), .tft_blue(tft_blue),
      .tft_data_ena(tft_data_ena), .tft_hsync(tft_hsync), .tft_vsync(tft_vsync),
      .tft_vdd(tft_vdd), .tft_display(tft_display),
      .new_frame(new_frame), .running(running)
   );

   always #5 tft_clk = ~tft_clk;

   // Pixel source: returns x + 16*y two clocks after the request.
   always @(posedge tft_clk) begin
      p0 <= {req_y, req_x};
      p1 <= p0;
   end
   assign pix_red   = p1;
   assign pix_green = ~p1;
   assign pix_blue  = 8'h5A;

   // Expected request/sync activity k clocks after entering RUN (7-clk lines, 6-line frames).
   function automatic bit m_rv(int k);
      return (k >= 0) && ((k % 7) < 4) && (((k / 7) % 6) < 3);
   endfunction
   function automatic bit m_hs(int k);
      return (k >= 0) && ((k % 7) == 5);
   endfunction
   function automatic bit m_vs(int k);
      return (k >= 0) && (((k / 7) % 6) == 4);
   endfunction
   function automatic logic [7:0] m_red(int cc);
      int k = cc - 3;
      return m_rv(k) ? 8'((k % 7) + 16 * ((k / 7) % 6)) : 8'h00;
   endfunction

   task automatic tick();
      @(posedge tft_clk);
      #1;
      c++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b0;
      repeat (3) @(posedge tft_clk);
      #1;
      checks++;
      if ({tft_vdd, tft_display, tft_data_ena, tft_hsync, tft_vsync, req_valid, new_frame, running,
           tft_red, tft_green, tft_blue} !== {8'b0001_1000, 24'h0}) begin
         failures++;
         $display("FAIL reset_state got vdd=%b disp=%b de=%b hs=%b vs=%b rv=%b nf=%b run=%b rgb=%h%h%h exp 0001_1000 rgb=0",
                  tft_vdd, tft_display, tft_data_ena, tft_hsync, tft_vsync, req_valid, new_frame, running,
                  tft_red, tft_green, tft_blue);
      end
   endtask

   task automatic test_power_up();
      rst = 1'b0;
      enable = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({tft_vdd, tft_display, running, new_frame, req_valid} !== {1'b1, {4{i == 4}}}) begin
            failures++;
            $display("FAIL power_up clk=%0d got vdd=%b disp=%b run=%b nf=%b rv=%b exp vdd=1 others=%b",
                     i, tft_vdd, tft_display, running, new_frame, req_valid, i == 4);
         end
      end
      checks++;
      if ({req_x, req_y} !== 8'h00) begin
         failures++;
         $display("FAIL power_up_xy got x=%0d y=%0d exp 0,0", req_x, req_y);
      end
      c = 0;
   endtask

   task automatic test_line_timing();
      int nrv = 0;
      int nhs = 0;
      for (int n = 0; n < 10; n++) begin
         checks++;
         if (req_valid !== m_rv(c) || req_x !== 4'(c % 7)) begin
            failures++;
            $display("FAIL line_req c=%0d got rv=%b x=%0d exp rv=%b x=%0d", c, req_valid, req_x, m_rv(c), c % 7);
         end
         checks++;
         if (tft_data_ena !== m_rv(c - 3) || tft_hsync !== !m_hs(c - 3)) begin
            failures++;
            $display("FAIL line_out c=%0d got de=%b hs=%b exp de=%b hs=%b", c, tft_data_ena, tft_hsync,
                     m_rv(c - 3), !m_hs(c - 3));
         end
         if (n < 7) nrv += int'(req_valid);
         nhs += int'(!tft_hsync);
         tick();
      end
      checks++;
      if (nrv != 4) begin
         failures++;
         $display("FAIL line_rv_count got=%0d exp=4", nrv);
      end
      checks++;
      if (nhs != 1) begin
         failures++;
         $display("FAIL line_hs_count got=%0d exp=1", nhs);
      end
   endtask

   task automatic test_frame_timing();
      int nvs = 0;
      int nnf = 0;
      int nde = 0;
      for (int n = 0; n < 84; n++) begin
         checks++;
         if (req_valid !== m_rv(c) || req_x !== 4'(c % 7) || req_y !== 4'((c / 7) % 6) ||
             new_frame !== (c % 42 == 0)) begin
            failures++;
            $display("FAIL frame_req c=%0d got rv=%b x=%0d y=%0d nf=%b", c, req_valid, req_x, req_y, new_frame);
         end
         checks++;
         if (tft_data_ena !== m_rv(c - 3) || tft_vsync !== !m_vs(c - 3)) begin
            failures++;
            $display("FAIL frame_out c=%0d got de=%b vs=%b exp de=%b vs=%b", c, tft_data_ena, tft_vsync,
                     m_rv(c - 3), !m_vs(c - 3));
         end
         nvs += int'(!tft_vsync);
         nnf += int'(new_frame);
         nde += int'(tft_data_ena);
         tick();
      end
      checks++;
      if (nvs != 14 || nnf != 2 || nde != 24) begin
         failures++;
         $display("FAIL frame_counts got vs=%0d nf=%0d de=%0d exp vs=14 nf=2 de=24", nvs, nnf, nde);
      end
   endtask

   task automatic test_pixel_path();
      logic [7:0] got[$];
      logic [7:0] seq_exp [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd16};
      while (c % 42 != 3) tick();
      for (int n = 0; n < 42; n++) begin
         checks++;
         if (tft_red !== m_red(c) || tft_blue !== (tft_data_ena ? 8'h5A : 8'h00)) begin
            failures++;
            $display("FAIL pixel c=%0d got red=%h blue=%h de=%b exp red=%h", c, tft_red, tft_blue, tft_data_ena, m_red(c));
         end
         if (tft_data_ena) got.push_back(tft_red);
         tick();
      end
      checks++;
      if (got.size() != 12) begin
         failures++;
         $display("FAIL pixel_count got=%0d exp=12", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== seq_exp[i]) begin
               failures++;
               $display("FAIL pixel_seq idx=%0d got=%0d exp=%0d", i, got[i], seq_exp[i]);
            end
         end
      end
   endtask

   task automatic test_drain_resume();
      while (c % 42 != 10) tick();
      enable = 1'b0;
      for (int n = 0; n < 36; n++) begin
         if (n == 2) enable = 1'b1;
         checks++;
         if (running !== 1'b1 || tft_display !== 1'b1 || new_frame !== (c % 42 == 0)) begin
            failures++;
            $display("FAIL drain_resume c=%0d got run=%b disp=%b nf=%b", c, running, tft_display, new_frame);
         end
         tick();
      end
   endtask

   task automatic test_power_down();
      while (c % 42 != 10) tick();
      enable = 1'b0;
      do begin
         checks++;
         if (running !== 1'b1 || tft_display !== 1'b1 || tft_vdd !== 1'b1 || req_valid !== m_rv(c)) begin
            failures++;
            $display("FAIL drain c=%0d got run=%b disp=%b vdd=%b rv=%b exp 1 1 1 %b", c, running, tft_display,
                     tft_vdd, req_valid, m_rv(c));
         end
         tick();
      end while (c % 42 != 0);
      for (int d = 1; d <= 4; d++) begin
         checks++;
         if ({tft_vdd, tft_display, running, req_valid, new_frame, tft_data_ena, tft_hsync, tft_vsync} !==
             {d < 4, 7'b0000011}) begin
            failures++;
            $display("FAIL disp_off d=%0d got vdd=%b disp=%b run=%b rv=%b nf=%b de=%b hs=%b vs=%b exp vdd=%b", d,
                     tft_vdd, tft_display, running, req_valid, new_frame, tft_data_ena, tft_hsync, tft_vsync, d < 4);
         end
         if (d == 2) enable = 1'b1;
         if (d < 4) tick();
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({tft_vdd, tft_display, running, new_frame} !== {1'b1, {3{i == 4}}}) begin
            failures++;
            $display("FAIL repower clk=%0d got vdd=%b disp=%b run=%b nf=%b", i, tft_vdd, tft_display, running, new_frame);
         end
      end
      c = 0;
   endtask

   task automatic test_reset_mid_frame();
      while (c % 42 != 2) tick();
      checks++;
      if (req_valid !== 1'b1 || req_x !== 4'd2) begin
         failures++;
         $display("FAIL pre_reset got rv=%b x=%0d exp rv=1 x=2", req_valid, req_x);
      end
      rst = 1'b1;
      #1;
      for (int n = 0; n < 2; n++) begin
         checks++;
         if ({tft_vdd, tft_display, tft_data_ena, tft_hsync, tft_vsync, req_valid, new_frame, running,
              tft_red, tft_green, tft_blue} !== {8'b0001_1000, 24'h0}) begin
            failures++;
            $display("FAIL mid_reset n=%0d got vdd=%b disp=%b de=%b hs=%b vs=%b rv=%b nf=%b run=%b", n, tft_vdd,
                     tft_display, tft_data_ena, tft_hsync, tft_vsync, req_valid, new_frame, running);
         end
         if (n == 0) tick();
      end
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({tft_vdd, req_valid, new_frame} !== {1'b1, {2{i == 4}}}) begin
            failures++;
            $display("FAIL post_reset clk=%0d got vdd=%b rv=%b nf=%b", i, tft_vdd, req_valid, new_frame);
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_line_timing();
      test_frame_timing();
      test_pixel_path();
      test_drain_resume();
      test_power_down();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tft_timing_gen.md
TFT_TIMING_GEN -- requirements
Module: tft_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hsync width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync width (lines)
- V_BP, 2, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIX_LAT, 2, clocks from pixel request to pixel data (1..8)
- PWR_DLY, 1024, power-sequencing wait (clocks, >= 1)
- X_BITS, 10, request x width
- Y_BITS, 9, request y width
- C_BITS, 8, bits per colour channel
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
- tft_clk  in  1  pixel clock, sole clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  panel on request (level)
- req_valid  out  1  pixel request strobe
- req_x  out  X_BITS  requested column
- req_y  out  Y_BITS  requested row
- pix_red/pix_green/pix_blue  in  C_BITS each  pixel data, valid PIX_LAT clocks after request
- tft_red/tft_green/tft_blue  out  C_BITS each  panel colour
- tft_data_ena  out  1  panel DE
- tft_hsync, tft_vsync  out  1 each  panel sync (level per SYNC_POL)
- tft_vdd, tft_display  out  1 each  panel supply / display-on controls
- new_frame  out  1  one-clock pulse at request of pixel (0,0)
- running  out  1  FSM in RUN or DRAIN

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; h_cnt SHALL count 0..H_TOTAL-1, wrap to 0 and advance v_cnt; v_cnt SHALL wrap from V_TOTAL-1 to 0.
REQ-004 Counters SHALL advance only in RUN/DRAIN and SHALL be held at 0 in all other states.
REQ-005 req_valid SHALL be 1 iff counters advance, h_cnt < H_ACTIVE and v_cnt < V_ACTIVE (strict; no off-by-one at H_ACTIVE/V_ACTIVE); req_x = h_cnt, req_y = v_cnt, both combinational from counters.
REQ-006 Raw hsync SHALL be active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines).
REQ-007 Raw DE, hsync and vsync SHALL pass through a PIX_LAT-stage delay line and then one output register, so tft_data_ena/tft_hsync/tft_vsync lag req_valid/counters by exactly PIX_LAT+1 clocks.
REQ-008 tft_red/green/blue SHALL be registered from pix_* on the clock the delayed DE is 1 (same edge as REQ-007's output register), and SHALL be 0 when that DE is 0.
REQ-009 new_frame SHALL be 1 for exactly the clock in which counters are (0,0) in RUN/DRAIN.
REQ-010 Power FSM states: OFF, VDD_WAIT, RUN, DRAIN, DISP_OFF; a PWR_DLY down-counter SHALL time VDD_WAIT and DISP_OFF.
REQ-011 OFF: vdd=0, display=0; enable=1 -> VDD_WAIT (load PWR_DLY).
REQ-012 VDD_WAIT: vdd=1, display=0; after PWR_DLY clocks -> RUN; enable=0 here -> OFF next clock.
REQ-013 RUN: vdd=1, display=1; enable=0 -> DRAIN.
REQ-014 DRAIN: as RUN; on clock with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 -> DISP_OFF (load PWR_DLY); enable re-asserted in DRAIN -> RUN (frame not interrupted).
REQ-015 DISP_OFF: vdd=1, display=0, delay-line flushed to inactive; after PWR_DLY clocks -> OFF regardless of enable.
REQ-016 running SHALL be 1 iff state is RUN or DRAIN.
REQ-017 tft_vdd and tft_display SHALL be registered outputs decoded from state.

Reset
REQ-018 rst=1 SHALL asynchronously force state OFF, counters 0, delay line inactive, PWR_DLY counter 0, and outputs: tft_vdd=0, tft_display=0, tft_data_ena=0, tft_hsync=tft_vsync=inactive level (~SYNC_POL), tft_red/green/blue=0, req_valid=0, new_frame=0, running=0.
REQ-019 rst asserted mid-frame or mid-sequence SHALL abort immediately to REQ-018 values; after release the FSM restarts from OFF.

Verification (H 4/1/1/1, V 3/1/1/1, PIX_LAT=2, PWR_DLY=3, SYNC_POL=0)
REQ-020 Power-up: enable=1 from reset -> vdd=1 after 1 clk, display=1 and new_frame pulse 3 clks later, first req_valid with (0,0).
REQ-021 Line timing: in RUN -> req_valid 4 of every 7 clks, hsync low on h_cnt=5 only, tft_data_ena high 3 clks after each req_valid.
REQ-022 Frame timing: 42-clk frame, vsync low for 7 clks on line 4, new_frame every 42 clks, no DE on lines 3-5.
REQ-023 Pixel path: drive pix_red = req_x+16*req_y delayed 2 clks -> tft_red sequence 0,1,2,3,16,... aligned with tft_data_ena; 0 during blanking.
REQ-024 Power-down: enable=0 mid-frame -> frame completes, DISP_OFF 3 clks with display=0 vdd=1, then OFF vdd=0; enable pulse back in DRAIN -> stays RUN.
REQ-025 Reset mid-frame: rst=1 at h_cnt=2 -> all outputs REQ-018 values in same clock, no further req_valid until power-up repeats.
